// File: rtl/motion_pkg.sv
// Shared motion definitions for the motion sequencer and the motor PWM driver.
package motion_pkg;

  typedef logic [2:0] motion_t;

  localparam motion_t M_FRONT  = 3'd0;
  localparam motion_t M_STOP   = 3'd1;
  localparam motion_t M_RIGHT  = 3'd2;
  localparam motion_t M_LEFT   = 3'd3;
  localparam motion_t M_SLEFT  = 3'd4;
  localparam motion_t M_SRIGHT = 3'd5;
  localparam motion_t M_BACK   = 3'd6;
  localparam motion_t M_SPEED  = 3'd7;

  localparam int CMD_DUR_W = 16;

  typedef struct packed {
    motion_t                motion;
    logic [CMD_DUR_W-1:0]   dur;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with synchronous flush; level uses an extra pointer bit.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 19
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/motion_sequencer.sv
// Plays queued (motion, ms) commands back-to-back onto the motor driver state input,
// with a STOP brake gap between differing non-STOP motions and a flushing abort.
module motion_sequencer
  import motion_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int DEPTH    = 4,
  parameter int DUR_W    = 16,
  parameter int GAP_MS   = 20
) (
  input  logic                   clk_50,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_motion,
  input  logic [DUR_W-1:0]       cmd_dur,
  input  logic                   abort,
  output logic [2:0]             motion_state,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] fifo_level
);

  // state    | meaning
  // ST_IDLE  | queue drained, driving STOP, popping as soon as a command arrives
  // ST_GAP   | brake gap, driving STOP for GAP_MS before the held command
  // ST_RUN   | driving the held command's motion until its ms count expires
  typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_RUN} state_t;

  localparam int PW = $clog2(TICK_DIV);
  localparam int GW = 16;

  state_t           state;
  motion_t          cur_motion;
  logic [DUR_W-1:0] remaining;
  logic [GW-1:0]    gap_ms;
  logic [PW-1:0]    presc;

  logic             fifo_full;
  logic             fifo_empty;
  logic [DUR_W+2:0] head;
  motion_t          head_motion;
  logic [DUR_W-1:0] head_dur;
  logic             push;
  logic             pop;
  logic             tick;
  logic             run_end;
  logic             need_gap;

  assign cmd_ready   = !fifo_full && !abort;
  assign push        = cmd_valid && cmd_ready;
  assign head_motion = head[DUR_W+2:DUR_W];
  assign head_dur    = head[DUR_W-1:0];
  assign tick        = (presc == PW'(TICK_DIV - 1));

  // A zero-length command completes in the cycle after it is popped.
  assign run_end = (state == ST_RUN) &&
                   ((remaining == '0) || (tick && remaining == DUR_W'(1)));

  assign pop = !abort && !fifo_empty && ((state == ST_IDLE) || run_end);

  assign need_gap = (GAP_MS > 0) && (motion_state != M_STOP) &&
                    (head_motion != M_STOP) && (head_motion != motion_state) &&
                    (head_dur != '0);

  assign busy = (state != ST_IDLE) || !fifo_empty;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (DUR_W + 3)
  ) u_fifo (
    .clk   (clk_50),
    .rst_n (rst_n),
    .flush (abort),
    .push  (push),
    .pop   (pop),
    .wdata ({cmd_motion, cmd_dur}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      motion_state <= M_STOP;
      cur_motion   <= M_STOP;
      remaining    <= '0;
      gap_ms       <= '0;
      presc        <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state        <= ST_IDLE;
        motion_state <= M_STOP;
        presc        <= '0;
      end else begin
        case (state)
          ST_IDLE: presc <= '0;
          ST_GAP: begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
              if (gap_ms == GW'(1)) begin
                state        <= ST_RUN;
                motion_state <= cur_motion;
              end else begin
                gap_ms <= gap_ms - 1'b1;
              end
            end
          end
          ST_RUN: begin
            presc <= tick ? '0 : presc + 1'b1;
            if (run_end) begin
              done <= 1'b1;
              if (fifo_empty) begin
                state        <= ST_IDLE;
                motion_state <= M_STOP;
                presc        <= '0;
              end
            end else if (tick) begin
              remaining <= remaining - 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase

        // Pop overrides the completion defaults above so back-to-back runs have no dead cycle.
        if (pop) begin
          remaining  <= head_dur;
          presc      <= '0;
          cur_motion <= head_motion;
          if (need_gap) begin
            state        <= ST_GAP;
            gap_ms       <= GW'(GAP_MS);
            motion_state <= M_STOP;
          end else begin
            state <= ST_RUN;
            if (head_dur != '0) motion_state <= head_motion;
          end
        end
      end
    end
  end

endmodule
